// File: rtl/uart_buffered.sv
// uart_buffered: buffered UART with TX/RX FIFOs, optional parity, 1 or 2 stop
// bits, a two-flop RX synchroniser, start-bit glitch rejection and sticky errors.
//
// Ports:
//   clk, reset        single clock, asynchronous active-high reset
//   data_in/_valid    TX word from producer; data_in_ready = TX FIFO not full
//   data_out/_valid   RX FIFO head (first-word fall-through); data_out_ready pops
//   serial_in         asynchronous RX line, idle high
//   serial_out        registered TX line, idle high
//   tx_busy           TX FIFO non-empty or a frame still on the line
//   rx_frame_err      sticky: stop bit sampled low
//   rx_parity_err     sticky: parity mismatch
//   rx_overrun        sticky: received word dropped, RX FIFO full
//   err_clear         pulse clearing the three sticky flags
module uart_buffered #(
  parameter int unsigned CLOCK_FREQ = 33_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned TX_DEPTH   = 16,
  parameter int unsigned RX_DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  input  logic                  serial_in,
  output logic                  serial_out,
  output logic                  tx_busy,
  output logic                  rx_frame_err,
  output logic                  rx_parity_err,
  output logic                  rx_overrun,
  input  logic                  err_clear
);

  localparam int unsigned SYMBOL = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CW     = $clog2(SYMBOL);
  localparam int unsigned TAW    = $clog2(TX_DEPTH);
  localparam int unsigned RAW    = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] SYM_LAST  = CW'(SYMBOL - 1);
  localparam logic [CW-1:0] SYM_MID   = CW'(SYMBOL / 2 - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0] r_tx_mem [TX_DEPTH];
  logic [TAW:0]          r_tx_wr, r_tx_rd;
  logic                  w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
  logic [DATA_WIDTH-1:0] w_tx_head;
  logic                  w_tx_head_par;

  assign w_tx_empty    = (r_tx_wr == r_tx_rd);
  assign w_tx_full     = (r_tx_wr[TAW] != r_tx_rd[TAW]) && (r_tx_wr[TAW-1:0] == r_tx_rd[TAW-1:0]);
  assign w_tx_push     = data_in_valid && !w_tx_full;
  assign w_tx_head     = r_tx_mem[r_tx_rd[TAW-1:0]];
  assign w_tx_head_par = (PARITY == 2) ? ~^w_tx_head : ^w_tx_head;
  assign data_in_ready = !w_tx_full;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[TAW-1:0]] <= data_in;
  end

  // ---------------- TX FSM ----------------
  tx_state_t             r_tx_state, w_tx_state_n;
  logic [CW-1:0]         r_tx_cnt, w_tx_cnt_n;
  logic [3:0]            r_tx_bit, w_tx_bit_n;
  logic [DATA_WIDTH-1:0] r_tx_shift, w_tx_shift_n;
  logic                  r_tx_par, w_tx_par_n;
  logic                  w_tx_line, w_tx_busy;
  logic                  r_serial_out, r_busy1, r_busy2;

  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_cnt_n   = r_tx_cnt;
    w_tx_bit_n   = r_tx_bit;
    w_tx_shift_n = r_tx_shift;
    w_tx_par_n   = r_tx_par;
    w_tx_pop     = 1'b0;
    w_tx_line    = 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        if (!w_tx_empty) begin
          w_tx_pop     = 1'b1;
          w_tx_shift_n = w_tx_head;
          w_tx_par_n   = w_tx_head_par;
          w_tx_cnt_n   = '0;
          w_tx_bit_n   = '0;
          w_tx_state_n = TX_START;
        end
      end
      TX_START: begin
        w_tx_line = 1'b0;
        if (r_tx_cnt == SYM_LAST) begin
          w_tx_cnt_n   = '0;
          w_tx_state_n = TX_DATA;
        end else w_tx_cnt_n = r_tx_cnt + CW'(1);
      end
      TX_DATA: begin
        w_tx_line = r_tx_shift[0];
        if (r_tx_cnt == SYM_LAST) begin
          w_tx_cnt_n   = '0;
          w_tx_shift_n = r_tx_shift >> 1;
          if (r_tx_bit == BIT_LAST) begin
            w_tx_bit_n = '0;
            if (PARITY != 0) w_tx_state_n = TX_PARITY;
            else             w_tx_state_n = TX_STOP;
          end else w_tx_bit_n = r_tx_bit + 4'(1);
        end else w_tx_cnt_n = r_tx_cnt + CW'(1);
      end
      TX_PARITY: begin
        w_tx_line = r_tx_par;
        if (r_tx_cnt == SYM_LAST) begin
          w_tx_cnt_n   = '0;
          w_tx_state_n = TX_STOP;
        end else w_tx_cnt_n = r_tx_cnt + CW'(1);
      end
      TX_STOP: begin
        w_tx_line = 1'b1;
        if (r_tx_cnt == SYM_LAST) begin
          w_tx_cnt_n = '0;
          if (r_tx_bit == STOP_LAST) begin
            w_tx_bit_n = '0;
            // Reload straight from the FIFO so consecutive frames have no gap.
            if (!w_tx_empty) begin
              w_tx_pop     = 1'b1;
              w_tx_shift_n = w_tx_head;
              w_tx_par_n   = w_tx_head_par;
              w_tx_state_n = TX_START;
            end else w_tx_state_n = TX_IDLE;
          end else w_tx_bit_n = r_tx_bit + 4'(1);
        end else w_tx_cnt_n = r_tx_cnt + CW'(1);
      end
      default: w_tx_state_n = TX_IDLE;
    endcase
  end

  assign w_tx_busy  = !w_tx_empty || (r_tx_state != TX_IDLE);
  assign serial_out = r_serial_out;
  // serial_out lags the FSM by one cycle; the second stage holds busy one
  // cycle past the end of the last stop bit on the line.
  assign tx_busy    = r_busy1 | r_busy2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_wr      <= '0;
      r_tx_rd      <= '0;
      r_tx_state   <= TX_IDLE;
      r_tx_cnt     <= '0;
      r_tx_bit     <= '0;
      r_tx_shift   <= '0;
      r_tx_par     <= 1'b0;
      r_serial_out <= 1'b1;
      r_busy1      <= 1'b0;
      r_busy2      <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + (TAW+1)'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + (TAW+1)'(1);
      r_tx_state   <= w_tx_state_n;
      r_tx_cnt     <= w_tx_cnt_n;
      r_tx_bit     <= w_tx_bit_n;
      r_tx_shift   <= w_tx_shift_n;
      r_tx_par     <= w_tx_par_n;
      r_serial_out <= w_tx_line;
      r_busy1      <= w_tx_busy;
      r_busy2      <= r_busy1;
    end
  end

  // ---------------- RX FSM ----------------
  logic                  r_sync1, r_sync2, r_rx_prev;
  rx_state_t             r_rx_state, w_rx_state_n;
  logic [CW-1:0]         r_rx_cnt, w_rx_cnt_n;
  logic [3:0]            r_rx_bit, w_rx_bit_n;
  logic [DATA_WIDTH-1:0] r_rx_shift, w_rx_shift_n;
  logic                  r_rx_par, w_rx_par_n;
  logic                  w_rx_par_bad, w_rx_push_req, w_ferr_evt, w_perr_evt;
  logic                  r_rx_push;
  logic [DATA_WIDTH-1:0] r_rx_word;

  assign w_rx_par_bad = (PARITY == 0) ? 1'b0 : ((^r_rx_shift ^ r_rx_par) != (PARITY == 2));

  always_comb begin
    w_rx_state_n  = r_rx_state;
    w_rx_cnt_n    = r_rx_cnt;
    w_rx_bit_n    = r_rx_bit;
    w_rx_shift_n  = r_rx_shift;
    w_rx_par_n    = r_rx_par;
    w_rx_push_req = 1'b0;
    w_ferr_evt    = 1'b0;
    w_perr_evt    = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev && !r_sync2) begin
          w_rx_cnt_n   = '0;
          w_rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (r_rx_cnt == SYM_MID) begin
          w_rx_cnt_n = '0;
          w_rx_bit_n = '0;
          if (r_sync2) w_rx_state_n = RX_IDLE;
          else         w_rx_state_n = RX_DATA;
        end else w_rx_cnt_n = r_rx_cnt + CW'(1);
      end
      RX_DATA: begin
        if (r_rx_cnt == SYM_LAST) begin
          w_rx_cnt_n   = '0;
          w_rx_shift_n = {r_sync2, r_rx_shift[DATA_WIDTH-1:1]};
          if (r_rx_bit == BIT_LAST) begin
            w_rx_bit_n = '0;
            if (PARITY != 0) w_rx_state_n = RX_PARITY;
            else             w_rx_state_n = RX_STOP;
          end else w_rx_bit_n = r_rx_bit + 4'(1);
        end else w_rx_cnt_n = r_rx_cnt + CW'(1);
      end
      RX_PARITY: begin
        if (r_rx_cnt == SYM_LAST) begin
          w_rx_cnt_n   = '0;
          w_rx_par_n   = r_sync2;
          w_rx_state_n = RX_STOP;
        end else w_rx_cnt_n = r_rx_cnt + CW'(1);
      end
      RX_STOP: begin
        if (r_rx_cnt == SYM_LAST) begin
          w_rx_cnt_n   = '0;
          w_rx_state_n = RX_WAIT;
          if (!r_sync2)          w_ferr_evt    = 1'b1;
          else if (w_rx_par_bad) w_perr_evt    = 1'b1;
          else                   w_rx_push_req = 1'b1;
        end else w_rx_cnt_n = r_rx_cnt + CW'(1);
      end
      RX_WAIT: begin
        if (r_sync2) w_rx_state_n = RX_IDLE;
      end
      default: w_rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_WIDTH-1:0] r_rx_mem [RX_DEPTH];
  logic [RAW:0]          r_rx_wr, r_rx_rd;
  logic                  w_rx_empty, w_rx_full, w_rx_pop, w_rx_wr, w_ovr_evt;
  logic                  r_frame_err, r_parity_err, r_overrun;

  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[RAW] != r_rx_rd[RAW]) && (r_rx_wr[RAW-1:0] == r_rx_rd[RAW-1:0]);
  assign w_rx_pop   = data_out_ready && !w_rx_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign w_rx_wr    = r_rx_push && (!w_rx_full || w_rx_pop);
  assign w_ovr_evt  = r_rx_push && w_rx_full && !w_rx_pop;

  assign data_out       = r_rx_mem[r_rx_rd[RAW-1:0]];
  assign data_out_valid = !w_rx_empty;
  assign rx_frame_err   = r_frame_err;
  assign rx_parity_err  = r_parity_err;
  assign rx_overrun     = r_overrun;

  always_ff @(posedge clk) begin
    if (w_rx_wr) r_rx_mem[r_rx_wr[RAW-1:0]] <= r_rx_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_par     <= 1'b0;
      r_rx_push    <= 1'b0;
      r_rx_word    <= '0;
      r_rx_wr      <= '0;
      r_rx_rd      <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sync1      <= serial_in;
      r_sync2      <= r_sync1;
      r_rx_prev    <= r_sync2;
      r_rx_state   <= w_rx_state_n;
      r_rx_cnt     <= w_rx_cnt_n;
      r_rx_bit     <= w_rx_bit_n;
      r_rx_shift   <= w_rx_shift_n;
      r_rx_par     <= w_rx_par_n;
      r_rx_push    <= w_rx_push_req;
      if (w_rx_push_req) r_rx_word <= r_rx_shift;
      if (w_rx_wr)  r_rx_wr <= r_rx_wr + (RAW+1)'(1);
      if (w_rx_pop) r_rx_rd <= r_rx_rd + (RAW+1)'(1);
      r_frame_err  <= (r_frame_err  && !err_clear) || w_ferr_evt;
      r_parity_err <= (r_parity_err && !err_clear) || w_perr_evt;
      r_overrun    <= (r_overrun    && !err_clear) || w_ovr_evt;
    end
  end

endmodule

// File: tb/tb_uart_buffered.sv
module tb_uart_buffered;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // DUT A: no parity, 1 stop, shallow FIFOs
  logic [7:0] din_a, dout_a;
  logic din_valid_a, din_ready_a, dout_valid_a, dout_ready_a;
  logic sin_a, sout_a, busy_a, ferr_a, perr_a, ovr_a, clr_a;
  logic rx_drv, lb_a;
  assign sin_a = lb_a ? sout_a : rx_drv;

  // DUT B: even parity, 2 stop bits, permanent loopback
  logic [7:0] din_b, dout_b;
  logic din_valid_b, din_ready_b, dout_valid_b, dout_ready_b;
  logic sin_b, sout_b, busy_b, ferr_b, perr_b, ovr_b, clr_b;
  assign sin_b = sout_b;

  uart_buffered #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
                  .PARITY(0), .STOP_BITS(1), .TX_DEPTH(4), .RX_DEPTH(4)) u_a (
    .clk(clk), .reset(rst),
    .data_in(din_a), .data_in_valid(din_valid_a), .data_in_ready(din_ready_a),
    .data_out(dout_a), .data_out_valid(dout_valid_a), .data_out_ready(dout_ready_a),
    .serial_in(sin_a), .serial_out(sout_a), .tx_busy(busy_a),
    .rx_frame_err(ferr_a), .rx_parity_err(perr_a), .rx_overrun(ovr_a), .err_clear(clr_a));

  uart_buffered #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
                  .PARITY(1), .STOP_BITS(2), .TX_DEPTH(16), .RX_DEPTH(16)) u_b (
    .clk(clk), .reset(rst),
    .data_in(din_b), .data_in_valid(din_valid_b), .data_in_ready(din_ready_b),
    .data_out(dout_b), .data_out_valid(dout_valid_b), .data_out_ready(dout_ready_b),
    .serial_in(sin_b), .serial_out(sout_b), .tx_busy(busy_b),
    .rx_frame_err(ferr_b), .rx_parity_err(perr_b), .rx_overrun(ovr_b), .err_clear(clr_b));

  int checks = 0;
  int errors = 0;
  int acc;
  logic rdy;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Line level of bit slot idx of a frame: start, 8 data LSB first, parity, stops.
  function automatic logic frame_bit(input logic [7:0] w, input int par, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return w[3'(idx - 1)];
    if (idx == 9 && par != 0) return (par == 1) ? ^w : ~^w;
    return 1'b1;
  endfunction

  // Called just after the edge that puts the start bit on the line.
  task automatic check_frame(input bit sel, input logic [7:0] w, input int par,
                             input int nstop, input string tag);
    int n;
    n = 9 + ((par != 0) ? 1 : 0) + nstop;
    for (int i = 0; i < n * 10; i++) begin
      chk(tag, sel ? sout_b : sout_a, frame_bit(w, par, i / 10));
      tick();
    end
  endtask

  task automatic wait_valid(input bit sel, input string tag);
    for (int i = 0; i < 300 && !(sel ? dout_valid_b : dout_valid_a); i++) tick();
    chk(tag, sel ? dout_valid_b : dout_valid_a, 1);
  endtask

  // Drives one 8N1 frame into DUT A; optionally checks the push latency
  // (valid rises 3 edges after the stop-bit mid-point edge).
  task automatic drive_rx(input logic [7:0] w, input logic stop, input bit lat);
    rx_drv = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 8; i++) begin
      rx_drv = w[i];
      repeat (10) tick();
    end
    rx_drv = stop;
    repeat (8) tick();
    if (lat) chk("rx_lat_before", dout_valid_a, 0);
    tick();
    if (lat) chk("rx_lat_edge", dout_valid_a, 1);
    tick();
    rx_drv = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    din_a = '0; din_valid_a = 0; dout_ready_a = 0; clr_a = 0; rx_drv = 1; lb_a = 0;
    din_b = '0; din_valid_b = 0; dout_ready_b = 0; clr_b = 0;
    repeat (3) tick();

    // Reset state
    chk("rst_sout_a", sout_a, 1);
    chk("rst_ready_a", din_ready_a, 1);
    chk("rst_valid_a", dout_valid_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_ferr_a", ferr_a, 0);
    chk("rst_perr_a", perr_a, 0);
    chk("rst_ovr_a", ovr_a, 0);
    chk("rst_sout_b", sout_b, 1);
    chk("rst_valid_b", dout_valid_b, 0);
    rst = 1'b0;
    repeat (5) tick();

    // 1: TX 0xA5 8N1
    din_a = 8'hA5; din_valid_a = 1;
    tick();
    din_valid_a = 0;
    chk("t1_busy_n0", busy_a, 0);
    chk("t1_sout_n0", sout_a, 1);
    tick();
    chk("t1_busy_n1", busy_a, 1);
    chk("t1_sout_n1", sout_a, 1);
    tick();
    check_frame(0, 8'hA5, 0, 1, "t1_frame");
    chk("t1_idle_line", sout_a, 1);
    chk("t1_busy_hold", busy_a, 1);
    tick();
    chk("t1_busy_drop", busy_a, 0);

    // 2: loopback even parity, 2 stop bits, 0x07 -> parity bit 1, 120 cycles
    din_b = 8'h07; din_valid_b = 1;
    tick();
    din_valid_b = 0;
    tick();
    tick();
    check_frame(1, 8'h07, 1, 2, "t2_frame");
    chk("t2_idle_line", sout_b, 1);
    wait_valid(1, "t2_rx_valid");
    chk("t2_dout", dout_b, 8'h07);
    chk("t2_ferr", ferr_b, 0);
    chk("t2_perr", perr_b, 0);
    chk("t2_ovr", ovr_b, 0);
    dout_ready_b = 1;
    tick();
    dout_ready_b = 0;
    chk("t2_popped", dout_valid_b, 0);

    // 3: stop bit low, then clear, then a short glitch
    drive_rx(8'h3C, 1'b0, 1'b0);
    chk("t3_ferr_set", ferr_a, 1);
    chk("t3_no_push", dout_valid_a, 0);
    chk("t3_perr", perr_a, 0);
    repeat (5) tick();
    clr_a = 1;
    tick();
    clr_a = 0;
    chk("t3_ferr_clr", ferr_a, 0);
    rx_drv = 0;
    repeat (3) tick();
    rx_drv = 1;
    repeat (30) tick();
    chk("t3_glitch_valid", dout_valid_a, 0);
    chk("t3_glitch_ferr", ferr_a, 0);

    // 4: overrun with RX_DEPTH = 4
    for (int i = 1; i <= 4; i++) drive_rx(8'(i), 1'b1, i == 1);
    chk("t4_valid4", dout_valid_a, 1);
    chk("t4_ovr4", ovr_a, 0);
    drive_rx(8'h05, 1'b1, 1'b0);
    chk("t4_valid5", dout_valid_a, 1);
    chk("t4_ovr5", ovr_a, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("t4_drain_valid", dout_valid_a, 1);
      chk("t4_drain_data", dout_a, 32'(i));
      dout_ready_a = 1;
      tick();
      dout_ready_a = 0;
    end
    chk("t4_empty", dout_valid_a, 0);
    clr_a = 1;
    tick();
    clr_a = 0;
    chk("t4_ovr_clr", ovr_a, 0);
    repeat (10) tick();

    // 5: TX_DEPTH = 4 backpressure, six back-to-back frames
    acc = 0;
    din_a = 8'h10; din_valid_a = 1;
    for (int c = 0; c < 603; c++) begin
      rdy = din_ready_a;
      tick();
      if (din_valid_a && rdy) begin
        acc++;
        if (acc == 5) chk("t5_ready_low", din_ready_a, 0);
        if (acc < 6) din_a = 8'(8'h10 + acc);
        else din_valid_a = 0;
      end
      if (c >= 2 && c < 602)
        chk("t5_line", sout_a, frame_bit(8'(8'h10 + (c - 2) / 100), 0, ((c - 2) % 100) / 10));
      if (c == 602) chk("t5_idle", sout_a, 1);
    end
    chk("t5_accepted", acc, 6);
    repeat (5) tick();

    // 6: reset mid-TX (3rd data bit) and mid-RX
    drive_rx(8'h77, 1'b1, 1'b0);
    chk("t6_rx_held", dout_valid_a, 1);
    lb_a = 1;
    din_a = 8'h5A; din_valid_a = 1;
    tick();
    din_a = 8'h33;
    tick();
    din_valid_a = 0;
    repeat (35) tick();
    chk("t6_pre_bit2", sout_a, 0);
    chk("t6_pre_busy", busy_a, 1);
    rst = 1;
    #1;
    chk("t6_rst_sout", sout_a, 1);
    chk("t6_rst_valid", dout_valid_a, 0);
    chk("t6_rst_ready", din_ready_a, 1);
    chk("t6_rst_busy", busy_a, 0);
    tick();
    tick();
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t6_post_line", sout_a, 1);
    end
    chk("t6_post_busy", busy_a, 0);
    chk("t6_post_valid", dout_valid_a, 0);
    din_a = 8'hC3; din_valid_a = 1;
    tick();
    din_valid_a = 0;
    tick();
    tick();
    check_frame(0, 8'hC3, 0, 1, "t6_frame");
    wait_valid(0, "t6_rx_valid");
    chk("t6_dout", dout_a, 8'hC3);
    chk("t6_ferr", ferr_a, 0);
    chk("t6_perr", perr_a, 0);
    chk("t6_ovr", ovr_a, 0);
    dout_ready_a = 1;
    tick();
    dout_ready_a = 0;
    chk("t6_popped", dout_valid_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_buffered.md
# uart_buffered

Parametrised, buffered successor to the team's basic UART. Adds transmit and receive FIFOs, optional parity, one or two stop bits, a two-flop input synchroniser, start-bit glitch rejection and sticky error flags. It sits between fabric-side ready/valid producers and consumers and the board serial pins, as a drop-in replacement wherever UART traffic must tolerate bursty software.

## Interface
- CLOCK_FREQ, 33_000_000: clk frequency in Hz.
- BAUD_RATE, 115_200: line rate. SYMBOL = CLOCK_FREQ / BAUD_RATE (integer division); SYMBOL must be at least 4.
- DATA_WIDTH, 8: data bits per frame, 5 to 9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- TX_DEPTH, 16: TX FIFO entries; power of 2, at least 2.
- RX_DEPTH, 16: RX FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  single clock; all logic rises on posedge.
- reset  in  1  asynchronous, active-high.
- data_in  in  DATA_WIDTH  word to transmit.
- data_in_valid  in  1  producer has a word.
- data_in_ready  out  1  TX FIFO not full.
- data_out  out  DATA_WIDTH  head of RX FIFO (first-word fall-through).
- data_out_valid  out  1  RX FIFO not empty.
- data_out_ready  in  1  consumer pops the head.
- serial_in  in  1  asynchronous RX line, idle high.
- serial_out  out  1  registered TX line, idle high.
- tx_busy  out  1  TX FIFO non-empty or a frame is in flight.
- rx_frame_err  out  1  sticky: stop bit sampled low.
- rx_parity_err  out  1  sticky: parity mismatch.
- rx_overrun  out  1  sticky: a received word was dropped because the RX FIFO was full.
- err_clear  in  1  one-cycle pulse that clears all three sticky flags.

## Operation
- Handshakes: a transfer occurs on any posedge where valid and ready are both high. Data must be held stable while valid is high and ready is low.
- Frame format: start (0), then data LSB first, then parity if PARITY != 0, then STOP_BITS stop bits (1). Every bit lasts SYMBOL cycles.
- Parity: even parity makes the count of ones across data+parity even; odd parity makes it odd.
- TX state machine: IDLE → START → DATA → PARITY (skipped when PARITY = 0) → STOP → IDLE.
  - In IDLE with the FIFO non-empty, the FSM pops one word and enters START.
  - A bit counter and a SYMBOL counter drive all transitions.
  - Back-to-back frames are sent with no idle gap.
- RX path: serial_in → 2-flop synchroniser (reset value 1) → RX state machine: IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE detects a falling edge on the synchronised line.
  - START resamples at SYMBOL/2. If the line is high there, treat it as a glitch and return to IDLE.
  - All later bits are sampled at mid-bit.
  - With STOP_BITS = 2, only the first stop bit is checked.
- Stop-bit outcome:
  - Stop bit low: set rx_frame_err and discard the word.
  - Stop bit high with parity mismatch: set rx_parity_err and discard the word.
  - Otherwise: push the word.
  - After the stop-bit sample, RX waits for the line to be high, then returns to IDLE.
- RX FIFO push when full: the word is dropped and rx_overrun is set, unless a pop occurs in the same cycle, in which case the push is accepted.
- TX FIFO: a simultaneous push and pop while full is not possible, because data_in_ready is low when the FIFO is full.
- FIFO pointers are log2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty and wraps naturally.
- Sticky flags:
  - If err_clear and a new error event occur in the same cycle, the flag is set.
  - err_clear has no effect on the FIFOs.

## Timing
- Reset values, applied immediately and asynchronously:
  - serial_out = 1, data_in_ready = 1, data_out_valid = 0, tx_busy = 0.
  - All error flags = 0, both FIFOs empty, both FSMs in IDLE.
- Reset mid-frame aborts the frame and flushes both FIFOs. serial_out returns high with no partial stop bit.
- TX latency: a word accepted at edge N into an empty, idle TX path gives serial_out = 0 starting at edge N+2.
- tx_busy rises at edge N+1 and falls one cycle after the last stop bit ends.
- RX latency: data_out_valid rises 3 cycles after the serial_in stop-bit mid-point sample edge: 2 cycles in the synchroniser plus 1 for the push.
- data_in_ready falls on the edge where the TX FIFO reaches TX_DEPTH entries.

## Test plan
Bench parameters: CLOCK_FREQ = 1_000_000, BAUD_RATE = 100_000 (SYMBOL = 10), DATA_WIDTH = 8, unless stated otherwise.

1. TX 0xA5, PARITY = 0, STOP_BITS = 1 → serial_out shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 10 cycles. The frame totals 100 cycles, and tx_busy drops 1 cycle after it ends.
2. Loopback (serial_out to serial_in), PARITY = 1, STOP_BITS = 2, send 0x07 → TX parity bit = 1 and the frame is 120 cycles. RX delivers data_out = 0x07 with all error flags at 0.
3. Drive a frame for 0x3C with the stop bit low → rx_frame_err = 1 and no push. Then pulse err_clear → flag = 0. Drive a glitch low for 3 cycles → no reception.
4. RX_DEPTH = 4, data_out_ready = 0, receive 0x01..0x05 → data_out_valid = 1 and rx_overrun = 1 after the 5th word. Draining yields exactly 0x01, 0x02, 0x03, 0x04.
5. TX_DEPTH = 4, hold data_in_valid high with 0x10..0x15 → data_in_ready goes low after 5 acceptances. All 6 words appear on serial_out in order, back-to-back.
6. Assert reset during the 3rd data bit of a TX frame and mid-RX → serial_out = 1 immediately, FIFOs empty, data_out_valid = 0. The next frame after release is transmitted and received correctly.
